// File: rtl/sump_pkg.sv
// Shared SUMP definitions: opcode constants, decoder state encoding and the
// long/short opcode decode helpers used by the command front end.
package sump_pkg;

    localparam logic [7:0] OP_RESET     = 8'h00;
    localparam logic [7:0] OP_ARM       = 8'h01;
    localparam logic [7:0] OP_ID        = 8'h02;
    localparam logic [7:0] OP_META      = 8'h04;
    localparam logic [7:0] OP_FINISH    = 8'h05;
    localparam logic [7:0] OP_DIV       = 8'h80;
    localparam logic [7:0] OP_SIZE      = 8'h81;
    localparam logic [7:0] OP_FLAGS     = 8'h82;
    localparam logic [7:0] OP_TRIG_BASE = 8'hC0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    typedef struct packed {
        logic       wr_flags;
        logic       wr_divider;
        logic       wr_size;
        logic [3:0] trig_mask;
        logic [3:0] trig_value;
        logic [3:0] trig_config;
    } wr_strobe_t;

    typedef struct packed {
        logic reset;
        logic arm;
        logic id;
        logic meta;
        logic finish;
    } short_pulse_t;

    // An all-zero result means the opcode is not recognised.
    function automatic wr_strobe_t decode_long(input logic [7:0] op);
        wr_strobe_t s;
        s = '0;
        if (op == OP_DIV) begin
            s.wr_divider = 1'b1;
        end else if (op == OP_SIZE) begin
            s.wr_size = 1'b1;
        end else if (op == OP_FLAGS) begin
            s.wr_flags = 1'b1;
        end else if (op[7:4] == OP_TRIG_BASE[7:4]) begin
            // op[3:2] selects the trigger stage, op[1:0] the register in it.
            case (op[1:0])
                2'd0:    s.trig_mask   = 4'b0001 << op[3:2];
                2'd1:    s.trig_value  = 4'b0001 << op[3:2];
                2'd2:    s.trig_config = 4'b0001 << op[3:2];
                default: s = '0;
            endcase
        end
        return s;
    endfunction

    function automatic short_pulse_t decode_short(input logic [7:0] op);
        short_pulse_t p;
        p = '0;
        case (op)
            OP_RESET:  p.reset  = 1'b1;
            OP_ARM:    p.arm    = 1'b1;
            OP_ID:     p.id     = 1'b1;
            OP_META:   p.meta   = 1'b1;
            OP_FINISH: p.finish = 1'b1;
            default:   p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sump_cmd_decoder_if.sv
// Host byte stream from the UART receiver into the command decoder.
interface sump_cmd_decoder_if;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (output rx_data, output rx_valid);
    modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/sump_cmd_decoder.sv
// SUMP command front end: decodes short commands into pulses and assembles
// 5-byte long commands into config_data plus a single write strobe.
module sump_cmd_decoder
    import sump_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                     clock,
    input  logic                     extReset_n,
    sump_cmd_decoder_if.slave        rx,
    output logic [31:0]              config_data,
    output logic                     wrFlags,
    output logic                     wrDivider,
    output logic                     wrSize,
    output logic [3:0]               wrTrigMask,
    output logic [3:0]               wrTrigValue,
    output logic [3:0]               wrTrigConfig,
    output logic                     cmd_reset,
    output logic                     cmd_arm,
    output logic                     cmd_id,
    output logic                     cmd_meta,
    output logic                     finish_now,
    output logic                     err_unknown,
    output logic                     err_timeout,
    output logic                     busy
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t       state, state_n;
    logic [1:0]   byte_cnt, byte_cnt_n;
    logic [7:0]   opcode, opcode_n;
    logic [31:0]  shadow, shadow_n;
    logic [31:0]  config_n;
    logic [TW-1:0] tmo_cnt, tmo_n;
    wr_strobe_t   strobe_q, strobe_n;
    short_pulse_t short_q, short_n;
    logic         err_unknown_n, err_timeout_n;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_n       = state;
        byte_cnt_n    = byte_cnt;
        opcode_n      = opcode;
        shadow_n      = shadow;
        config_n      = config_data;
        tmo_n         = tmo_cnt;
        strobe_n      = '0;
        short_n       = '0;
        err_unknown_n = 1'b0;
        err_timeout_n = 1'b0;

        case (state)
            ST_IDLE: begin
                if (rx.rx_valid) begin
                    if (!rx.rx_data[7]) begin
                        short_n       = decode_short(rx.rx_data);
                        err_unknown_n = (short_n == '0);
                    end else begin
                        opcode_n   = rx.rx_data;
                        byte_cnt_n = 2'd0;
                        shadow_n   = '0;
                        tmo_n      = '0;
                        state_n    = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (rx.rx_valid) begin
                    // An arriving byte always beats a timeout expiring this cycle.
                    tmo_n      = '0;
                    byte_cnt_n = byte_cnt + 2'd1;
                    shadow_n[{byte_cnt, 3'b000} +: 8] = rx.rx_data;
                    if (byte_cnt == 2'd3) begin
                        state_n       = ST_IDLE;
                        config_n      = shadow_n;
                        strobe_n      = decode_long(opcode);
                        err_unknown_n = (strobe_n == '0);
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    state_n       = ST_IDLE;
                    byte_cnt_n    = 2'd0;
                    tmo_n         = '0;
                    err_timeout_n = 1'b1;
                end else begin
                    tmo_n = tmo_cnt + TW'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge extReset_n) begin
        if (!extReset_n) begin
            state       <= ST_IDLE;
            byte_cnt    <= 2'd0;
            opcode      <= 8'h00;
            shadow      <= '0;
            config_data <= '0;
            tmo_cnt     <= '0;
            strobe_q    <= '0;
            short_q     <= '0;
            err_unknown <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            byte_cnt    <= byte_cnt_n;
            opcode      <= opcode_n;
            shadow      <= shadow_n;
            config_data <= config_n;
            tmo_cnt     <= tmo_n;
            strobe_q    <= strobe_n;
            short_q     <= short_n;
            err_unknown <= err_unknown_n;
            err_timeout <= err_timeout_n;
        end
    end

    assign wrFlags      = strobe_q.wr_flags;
    assign wrDivider    = strobe_q.wr_divider;
    assign wrSize       = strobe_q.wr_size;
    assign wrTrigMask   = strobe_q.trig_mask;
    assign wrTrigValue  = strobe_q.trig_value;
    assign wrTrigConfig = strobe_q.trig_config;
    assign cmd_reset    = short_q.reset;
    assign cmd_arm      = short_q.arm;
    assign cmd_id       = short_q.id;
    assign cmd_meta     = short_q.meta;
    assign finish_now   = short_q.finish;
    assign busy         = (state == ST_DATA);

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Directed-vector bench for sump_cmd_decoder with a short timeout window.
module tb_sump_cmd_decoder;

    logic        clock = 1'b0;
    logic        extReset_n = 1'b0;
    logic [31:0] config_data;
    logic        wrFlags, wrDivider, wrSize;
    logic [3:0]  wrTrigMask, wrTrigValue, wrTrigConfig;
    logic        cmd_reset, cmd_arm, cmd_id, cmd_meta, finish_now;
    logic        err_unknown, err_timeout, busy;
    logic [21:0] pulses;

    int n_vec  = 0;
    int n_miss = 0;

    // Bit positions inside the pulses vector.
    localparam logic [21:0] P_NONE   = 22'h00_0000;
    localparam logic [21:0] P_FLAGS  = 22'h20_0000;
    localparam logic [21:0] P_DIV    = 22'h10_0000;
    localparam logic [21:0] P_SIZE   = 22'h08_0000;
    localparam logic [21:0] P_MASK2  = 22'h02_0000;
    localparam logic [21:0] P_VALUE1 = 22'h00_1000;
    localparam logic [21:0] P_CFG3   = 22'h00_0400;
    localparam logic [21:0] P_RESET  = 22'h00_0040;
    localparam logic [21:0] P_ARM    = 22'h00_0020;
    localparam logic [21:0] P_ID     = 22'h00_0010;
    localparam logic [21:0] P_META   = 22'h00_0008;
    localparam logic [21:0] P_FINISH = 22'h00_0004;
    localparam logic [21:0] P_UNK    = 22'h00_0002;
    localparam logic [21:0] P_TMO    = 22'h00_0001;

    sump_cmd_decoder_if rx_bus ();

    sump_cmd_decoder #(.TIMEOUT_CYCLES(8)) dut (
        .clock        (clock),
        .extReset_n   (extReset_n),
        .rx           (rx_bus.slave),
        .config_data  (config_data),
        .wrFlags      (wrFlags),
        .wrDivider    (wrDivider),
        .wrSize       (wrSize),
        .wrTrigMask   (wrTrigMask),
        .wrTrigValue  (wrTrigValue),
        .wrTrigConfig (wrTrigConfig),
        .cmd_reset    (cmd_reset),
        .cmd_arm      (cmd_arm),
        .cmd_id       (cmd_id),
        .cmd_meta     (cmd_meta),
        .finish_now   (finish_now),
        .err_unknown  (err_unknown),
        .err_timeout  (err_timeout),
        .busy         (busy)
    );

    assign pulses = {wrFlags, wrDivider, wrSize, wrTrigMask, wrTrigValue, wrTrigConfig,
                     cmd_reset, cmd_arm, cmd_id, cmd_meta, finish_now, err_unknown, err_timeout};

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drives one byte for one cycle; returns 1ns after the edge that took it.
    task automatic send_byte(input logic [7:0] b);
        rx_bus.rx_data  = b;
        rx_bus.rx_valid = 1'b1;
        @(posedge clock);
        #1;
        rx_bus.rx_valid = 1'b0;
        rx_bus.rx_data  = 8'h00;
    endtask

    task automatic send_long(input logic [7:0] op, input logic [31:0] payload);
        send_byte(op);
        for (int k = 0; k < 4; k++) send_byte(payload[8*k +: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    logic [7:0]  short_op [5] = '{8'h00, 8'h02, 8'h04, 8'h03, 8'h7F};
    logic [21:0] short_exp[5] = '{P_RESET, P_ID, P_META, P_UNK, P_UNK};
    logic [21:0] seen;

    initial begin
        rx_bus.rx_data  = 8'h00;
        rx_bus.rx_valid = 1'b0;
        idle(3);
        check("reset_pulses", 32'(pulses), 32'(P_NONE));
        check("reset_config", config_data, 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        extReset_n = 1'b1;
        idle(2);

        // Flags write, back-to-back bytes
        send_byte(8'h82);
        check("flags_busy_mid", 32'(busy), 32'h1);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        check("flags_strobe", 32'(pulses), 32'(P_FLAGS));
        check("flags_config", config_data, 32'h0000_0100);
        check("flags_busy_done", 32'(busy), 32'h0);
        idle(1);
        check("flags_width", 32'(pulses), 32'(P_NONE));

        // Trigger mask stage 2, arm accepted while the strobe is high
        send_long(8'hC8, 32'hDEADBEEF);
        check("trig_mask", 32'(pulses), 32'(P_MASK2));
        check("trig_config_data", config_data, 32'hDEADBEEF);
        send_byte(8'h01);
        check("arm_pulse", 32'(pulses), 32'(P_ARM));
        idle(1);
        check("arm_width", 32'(pulses), 32'(P_NONE));

        send_byte(8'h05);
        check("finish_pulse", 32'(pulses), 32'(P_FINISH));
        check("finish_config", config_data, 32'hDEADBEEF);

        send_long(8'hC5, 32'h04030201);
        check("trig_value1", 32'(pulses), 32'(P_VALUE1));
        send_long(8'hCE, 32'h88776655);
        check("trig_cfg3", 32'(pulses), 32'(P_CFG3));
        check("trig_cfg3_data", config_data, 32'h88776655);
        send_long(8'hC3, 32'h0000_0000);
        check("trig_unknown_c3", 32'(pulses), 32'(P_UNK));

        // Unknown long and short opcodes
        send_long(8'h9F, 32'h44332211);
        check("long_unknown", 32'(pulses), 32'(P_UNK));
        check("long_unknown_cfg", config_data, 32'h44332211);
        send_byte(8'h33);
        check("short_unknown", 32'(pulses), 32'(P_UNK));
        check("short_unknown_cfg", config_data, 32'h44332211);
        for (int i = 0; i < 5; i++) begin
            send_byte(short_op[i]);
            check($sformatf("short_%02h", short_op[i]), 32'(pulses), 32'(short_exp[i]));
        end
        idle(1);

        // Timeout after 8 idle cycles
        send_byte(8'h80); send_byte(8'h11);
        idle(7);
        check("tmo_not_yet", 32'(pulses), 32'(P_NONE));
        check("tmo_busy_before", 32'(busy), 32'h1);
        idle(1);
        check("tmo_pulse", 32'(pulses), 32'(P_TMO));
        check("tmo_busy_drop", 32'(busy), 32'h0);
        check("tmo_config_kept", config_data, 32'h44332211);
        idle(1);
        check("tmo_width", 32'(pulses), 32'(P_NONE));
        send_long(8'h80, 32'h0000_0004);
        check("div_after_tmo", 32'(pulses), 32'(P_DIV));
        check("div_after_tmo_cfg", config_data, 32'h0000_0004);

        // Byte landing on the expiry cycle wins and reloads the counter
        send_byte(8'h80); send_byte(8'hA1);
        idle(7);
        send_byte(8'hB2);
        check("collide_no_tmo", 32'(pulses), 32'(P_NONE));
        check("collide_busy", 32'(busy), 32'h1);
        idle(7);
        check("collide_reload", 32'(pulses), 32'(P_NONE));
        send_byte(8'hC3); send_byte(8'hD4);
        check("collide_div", 32'(pulses), 32'(P_DIV));
        check("collide_cfg", config_data, 32'hD4C3B2A1);

        // Reset in the middle of a command
        send_byte(8'h81); send_byte(8'hAA); send_byte(8'hBB);
        extReset_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_config", config_data, 32'h0);
        check("rst_mid_pulses", 32'(pulses), 32'(P_NONE));
        idle(2);
        extReset_n = 1'b1;
        seen = '0;
        for (int i = 0; i < 12; i++) begin
            idle(1);
            seen |= pulses;
        end
        check("rst_silent", 32'(seen), 32'(P_NONE));
        send_long(8'h81, 32'h04030201);
        check("size_after_rst", 32'(pulses), 32'(P_SIZE));
        check("size_after_rst_cfg", config_data, 32'h04030201);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sump_cmd_decoder.md
# sump_cmd_decoder

Command front end of the logic analyzer. It turns the host byte stream from the UART receiver into SUMP commands: 1-byte short commands and 5-byte long commands. It assembles each long command's 32-bit payload and drives it onto `config_data`. It then issues a one-cycle write strobe to exactly one configuration target: flags register, divider, size, or one of the trigger-stage registers. Short commands become one-cycle control pulses: reset, arm, ID query, metadata query, and `finish_now`, which clears the flags demux bit.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1000000: idle clocks allowed between bytes of one long command before it is discarded; must be ≥ 2.

Ports:
- `clock`  in  1  system clock; everything is on the rising edge.
- `extReset_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle qualifier for `rx_data`; may be high on consecutive cycles.
- `config_data`  out  32  assembled payload; holds until the next long command completes.
- `wrFlags`, `wrDivider`, `wrSize`  out  1 each  one-cycle write strobes.
- `wrTrigMask`, `wrTrigValue`, `wrTrigConfig`  out  4 each  one-hot per-stage write strobes.
- `cmd_reset`, `cmd_arm`, `cmd_id`, `cmd_meta`, `finish_now`  out  1 each  one-cycle short-command pulses.
- `err_unknown`, `err_timeout`  out  1 each  one-cycle diagnostic pulses.
- `busy`  out  1  high while a long command is partially received.

## Operation
- **States**
  - IDLE: waiting for an opcode byte.
  - DATA: collecting payload bytes; 2-bit `byte_cnt` counts 0..3.
- **IDLE**, byte accepted:
  - Bit 7 = 0 (short command): decode it and return a pulse next cycle.
    - 0x00 → `cmd_reset`
    - 0x01 → `cmd_arm`
    - 0x02 → `cmd_id`
    - 0x04 → `cmd_meta`
    - 0x05 → `finish_now`
    - any other value → `err_unknown`
  - Bit 7 = 1 (long command): latch the opcode, clear `byte_cnt`, go to DATA.
- **DATA**, byte accepted:
  - Payload is little-endian; byte k goes to bits [8k+7:8k].
  - `byte_cnt` increments.
  - On the 4th byte, go to IDLE and issue the decoded strobe.
- **Long-opcode decode**
  - 0x80 → `wrDivider`
  - 0x81 → `wrSize`
  - 0x82 → `wrFlags`
  - 0xC0 + 4s → `wrTrigMask[s]`
  - 0xC1 + 4s → `wrTrigValue[s]`
  - 0xC2 + 4s → `wrTrigConfig[s]`, where s = 0..3
  - Any other long opcode: all 4 payload bytes are still consumed, no write strobe fires, and `err_unknown` pulses; `config_data` is still updated.
- **Payload buffering**
  - Bytes assemble in a shadow register.
  - `config_data` loads from the shadow only on completion, so targets never see a partial word.
- **Timeout counter**
  - Reloads on every accepted byte.
  - Counts only in DATA.
  - On reaching `TIMEOUT_CYCLES`: return to IDLE, discard the partial command, pulse `err_timeout`, leave `config_data` unchanged.
- **Reset**
  - State goes to IDLE; counters, shadow and `config_data` go to 0.
  - All strobes, pulses and `busy` go to 0.
  - A reset in the middle of a command discards it silently, with no error pulse.

## Timing
- **Latency**
  - Short-command pulse is high in cycle N+1 when the opcode is accepted in cycle N.
  - Long-command strobe and new `config_data` are both valid in cycle N+1 after the 4th payload byte in cycle N.
- **Strobe width and exclusivity**
  - Every strobe and pulse is exactly 1 cycle wide.
  - At most one of the strobes/pulses is high in any cycle (`err_*` excepted).
- **Back-to-back input**
  - `rx_valid` may be high every cycle.
  - An opcode arriving in the cycle the previous long-command strobe is high is accepted normally; there are no bubbles.
- **Collision rule**: if a byte arrives in the same cycle the timeout would expire, the byte wins. It is accepted and the counter reloads.
- **Busy**: `busy` is registered — high from the cycle after the long opcode through the cycle the strobe is high, exclusive.

## Structure
- A shared package `sump_pkg` holds:
  - the opcode constants (`OP_RESET`, `OP_ARM`, `OP_ID`, `OP_META`, `OP_FINISH`, `OP_DIV`, `OP_SIZE`, `OP_FLAGS`, `OP_TRIG_BASE`);
  - the state encoding.
- No sub-module: the decoder, shadow register and timeout counter live in one module.
- Timeout counter width is `$clog2(TIMEOUT_CYCLES+1)`.

## Test plan
- **Flags write.** Bytes 0x82, 0x00, 0x01, 0x00, 0x00, back-to-back.
  - `wrFlags` pulses once, one cycle after the last byte.
  - `config_data` = 0x0000_0100.
  - No other strobe fires.
- **Trigger stage decode.** 0xC8 with payload 0xDEADBEEF (LE bytes EF BE AD DE), immediately followed by short 0x01.
  - `wrTrigMask` = 4'b0100 and `config_data` = 0xDEADBEEF.
  - `cmd_arm` pulses on the next cycle.
- **Finish.** Short 0x05 → `finish_now` high for 1 cycle; `config_data` unchanged.
- **Unknown opcodes.**
  - Long 0x9F plus 4 bytes → `err_unknown` pulses, no write strobe, `config_data` updated.
  - Short 0x33 → `err_unknown` pulses only.
- **Timeout.** With `TIMEOUT_CYCLES`=8: send 0x80, 0x11, then idle.
  - After 8 idle cycles: `err_timeout` pulses and `busy` drops.
  - The next 0x80 + 4 bytes (0x04 0x00 0x00 0x00) yields `wrDivider` with `config_data` = 0x4.
  - In the same run, a byte arriving on the expiry cycle is accepted and no `err_timeout` fires.
- **Reset mid-command.** Assert `extReset_n`=0 after 2 payload bytes.
  - All outputs go to 0 immediately.
  - After release, a complete 0x81 command decodes correctly as `wrSize`.
